// File: rtl/sberday_btn_pkg.sv
// Shared definitions for the board button debouncer: channel map and default filter lengths.
// CNT_W_SIM shortens the filter so simulations settle in tens of cycles instead of 2^16.
package sberday_btn_pkg;

  typedef enum int unsigned {
    BTN_C = 0,
    BTN_U = 1,
    BTN_L = 2,
    BTN_R = 3,
    BTN_D = 4
  } btn_ch_e;

  localparam int N_CH_DEF        = 5;
  localparam int CNT_W_DEF       = 16;
  localparam int LONG_W_DEF      = 26;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_SIM       = 4;

  // Cycles from a clean pin edge to the debounced level change.
  function automatic int debounce_latency(input int cnt_w, input int sync_stages);
    return sync_stages + (1 << cnt_w);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, agreement filter, press/release/long-press pulses.
// Latency SYNC_STAGES + 2^CNT_W cycles pin-to-state; no backpressure, pulses are single-cycle registered.
module debounce_ch #(
  parameter int   CNT_W       = 16,
  parameter int   LONG_W      = 26,
  parameter int   SYNC_STAGES = 2,
  parameter logic ACT_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [LONG_W-1:0] HOLD_MAX = {LONG_W{1'b1}};
  localparam logic [LONG_W-1:0] HOLD_PRE = HOLD_MAX - 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   norm;
  logic [CNT_W-1:0]       cnt;
  logic [LONG_W-1:0]      hold_cnt;

  // Reset loads the idle pin level so an active-low input does not look pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{ACT_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign norm = sync_q[SYNC_STAGES-1] ^ ACT_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (norm == state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        state <= norm;
        cnt   <= '0;
        press <= norm;
        rel   <= ~norm;
      end
    end
  end

  // Saturating hold counter; the pulse fires on the step into MAX, so once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!state) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt   <= hold_cnt + 1'b1;
        long_press <= (hold_cnt == HOLD_PRE);
      end
    end
  end

endmodule

// File: rtl/multi_btn_debouncer.sv
// N-channel button debouncer: one debounce_ch per pin, polarity mask mapped per channel.
// Latency SYNC_STAGES + 2^CNT_W cycles; no backpressure, all outputs registered.
module multi_btn_debouncer
  import sberday_btn_pkg::*;
#(
  parameter int              N_CH         = N_CH_DEF,
  parameter int              CNT_W        = CNT_W_DEF,
  parameter int              LONG_W       = LONG_W_DEF,
  parameter int              SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter logic [N_CH-1:0] ACT_LOW_MASK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W       (CNT_W),
      .LONG_W      (LONG_W),
      .SYNC_STAGES (SYNC_STAGES),
      .ACT_LOW     (ACT_LOW_MASK[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (btn_raw[i]),
      .state      (btn_state[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i]),
      .long_press (btn_long[i])
    );
  end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Directed bench for multi_btn_debouncer with a 16-cycle filter and 63-cycle long press.
module tb_multi_btn_debouncer;
  import sberday_btn_pkg::*;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_state, btn_press, btn_release, btn_long;

  int checks   = 0;
  int failures = 0;

  multi_btn_debouncer #(
    .N_CH         (N),
    .CNT_W        (CNT_W_SIM),
    .LONG_W       (6),
    .SYNC_STAGES  (2),
    .ACT_LOW_MASK (5'b00001)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] st, input logic [N-1:0] pr,
                         input logic [N-1:0] rl, input logic [N-1:0] lg);
    chk({tag, ".state"},   btn_state,   st);
    chk({tag, ".press"},   btn_press,   pr);
    chk({tag, ".release"}, btn_release, rl);
    chk({tag, ".long"},    btn_long,    lg);
  endtask

  // Advance n rising edges, checking all outputs 1ns after each edge.
  task automatic run(input string tag, input int n, input logic [N-1:0] st, input logic [N-1:0] pr,
                     input logic [N-1:0] rl, input logic [N-1:0] lg);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk_all(tag, st, pr, rl, lg);
    end
  endtask

  initial begin
    btn_raw = 5'b00001;
    rst_n   = 1'b0;
    #12;
    chk_all("reset", 5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clk) rst_n = 1'b1;
    run("idle", 100, 5'b0, 5'b0, 5'b0, 5'b0);

    // ch1 press: 2 sync + 16 filter cycles
    @(negedge clk) btn_raw = 5'b00011;
    run("ch1_wait", 17, 5'b0, 5'b0, 5'b0, 5'b0);
    run("ch1_press", 1, 5'b00010, 5'b00010, 5'b0, 5'b0);

    // long press 63 cycles after the press edge, then never again
    run("ch1_hold", 62, 5'b00010, 5'b0, 5'b0, 5'b0);
    run("ch1_long", 1, 5'b00010, 5'b0, 5'b0, 5'b00010);
    run("ch1_sat", 20, 5'b00010, 5'b0, 5'b0, 5'b0);

    @(negedge clk) btn_raw = 5'b00001;
    run("ch1_rel_wait", 17, 5'b00010, 5'b0, 5'b0, 5'b0);
    run("ch1_release", 1, 5'b0, 5'b0, 5'b00010, 5'b0);

    // ch2 bounce shorter than the filter never gets through
    for (int t = 0; t < 6; t++) begin
      @(negedge clk) btn_raw[2] = ~btn_raw[2];
      run("ch2_bounce", 5, 5'b0, 5'b0, 5'b0, 5'b0);
    end
    @(negedge clk) btn_raw[2] = 1'b1;
    run("ch2_wait", 17, 5'b0, 5'b0, 5'b0, 5'b0);
    run("ch2_press", 1, 5'b00100, 5'b00100, 5'b0, 5'b0);
    @(negedge clk) btn_raw[2] = 1'b0;
    run("ch2_rel_wait", 17, 5'b00100, 5'b0, 5'b0, 5'b0);
    run("ch2_release", 1, 5'b0, 5'b0, 5'b00100, 5'b0);

    // ch0 active-low plus ch3/ch4 in the same cycle
    @(negedge clk) btn_raw = 5'b11000;
    run("multi_wait", 17, 5'b0, 5'b0, 5'b0, 5'b0);
    run("multi_press", 1, 5'b11001, 5'b11001, 5'b0, 5'b0);
    @(negedge clk) btn_raw = 5'b11001;
    run("ch0_rel_wait", 17, 5'b11001, 5'b0, 5'b0, 5'b0);
    run("ch0_release", 1, 5'b11000, 5'b0, 5'b00001, 5'b0);
    run("ch34_hold", 44, 5'b11000, 5'b0, 5'b0, 5'b0);
    run("ch34_long", 1, 5'b11000, 5'b0, 5'b0, 5'b11000);
    @(negedge clk) btn_raw = 5'b00001;
    run("ch34_rel_wait", 17, 5'b11000, 5'b0, 5'b0, 5'b0);
    run("ch34_release", 1, 5'b0, 5'b0, 5'b11000, 5'b0);

    // reset in the middle of ch1 filtering (cnt=10)
    @(negedge clk) btn_raw = 5'b00011;
    run("ch1_filter", 12, 5'b0, 5'b0, 5'b0, 5'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_mid_filter", 5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clk) rst_n = 1'b1;
    run("ch1_rst_wait", 17, 5'b0, 5'b0, 5'b0, 5'b0);
    run("ch1_repress", 1, 5'b00010, 5'b00010, 5'b0, 5'b0);

    // reset while held: press re-reported and long-press count restarts
    run("ch1_held", 5, 5'b00010, 5'b0, 5'b0, 5'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_held", 5'b0, 5'b0, 5'b0, 5'b0);
    run("in_reset", 3, 5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clk) rst_n = 1'b1;
    run("ch1_rst2_wait", 17, 5'b0, 5'b0, 5'b0, 5'b0);
    run("ch1_repress2", 1, 5'b00010, 5'b00010, 5'b0, 5'b0);
    run("ch1_rehold", 62, 5'b00010, 5'b0, 5'b0, 5'b0);
    run("ch1_relong", 1, 5'b00010, 5'b0, 5'b0, 5'b00010);
    run("ch1_resat", 5, 5'b00010, 5'b0, 5'b0, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
